mem_req_demux: RTL and testbench
================================

// Module: mem_req_demux
// PURPOSE
//  Routes one valid/ready memory request stream to NoMstPorts slaves using addr_decode's index.
//  Sits directly downstream of addr_decode, between core LSU/IFU bus and peripheral/memory ports.
//  Keeps responses in order by locking onto one target while transactions are outstanding.
//  Answers unmapped addresses from an internal error responder.
// PARAMETERS
//  NoMstPorts  4             number of downstream ports
//  NoRules     4             address-map rules passed to addr_decode
//  AddrWidth   32            address width
//  DataWidth   32            data width; strobe width = DataWidth/8
//  MaxTrans    4             max outstanding transactions to the locked target (>=1)
//  rule_t      mem_demux_pkg::rule_t  {idx, start_addr, end_addr}
//  ErrData     32'hBADCAB1E  rdata returned on decode error
// PORTS
//  clk_i             in   1                  clock
//  rst_i             in   1                  synchronous, active-high reset
//  addr_map_i        in   NoRules*rule_t     address map
//  en_default_idx_i  in   1                  enable default port
//  default_idx_i     in   IdxW               default port index
//  slv_req_valid_i   in   1                  upstream request valid
//  slv_req_ready_o   out  1                  upstream request ready
//  slv_req_addr_i    in   AddrWidth          request address
//  slv_req_we_i      in   1                  1 = write
//  slv_req_wdata_i   in   DataWidth          write data
//  slv_req_strb_i    in   DataWidth/8        byte strobes
//  slv_rsp_valid_o   out  1                  upstream response valid
//  slv_rsp_ready_i   in   1                  upstream response ready
//  slv_rsp_rdata_o   out  DataWidth          read data
//  slv_rsp_err_o     out  1                  error flag
//  mst_req_valid_o   out  NoMstPorts         per-port request valid
//  mst_req_ready_i   in   NoMstPorts         per-port request ready
//  mst_req_{addr,we,wdata,strb}_o  out  as slv  broadcast request payload
//  mst_rsp_valid_i   in   NoMstPorts         per-port response valid
//  mst_rsp_ready_o   out  NoMstPorts         per-port response ready
//  mst_rsp_rdata_i   in   NoMstPorts*DataWidth  per-port read data
//  mst_rsp_err_i     in   NoMstPorts         per-port error
// BEHAVIOUR
//  - Target t = dec_error ? ERR (virtual index NoMstPorts) : decoded idx.
//  - State: cnt_q in 0..MaxTrans, sel_q in 0..NoMstPorts.
//  - accept = cnt_q==0 | (sel_q==t & cnt_q<MaxTrans).
//  - mst_req_valid_o[i] = slv_req_valid_i & accept & t==i.
//  - slv_req_ready_o = accept & (t==ERR | mst_req_ready_i[t]).
//  - No valid depends on a ready.
//  - Request handshake: sel_q<=t. Response handshake: rsp_hs.
//  - cnt_q +1 on request handshake, -1 on rsp_hs, unchanged on both in the same cycle.
//  - Switching target stalls (ready=0) until cnt_q drains to 0.
//  - cnt_q==MaxTrans stalls the same target.
//  - Response mux from sel_q; mst_rsp_ready_o[sel_q]=slv_rsp_ready_i, all others 0.
//  - Responses on unselected ports are ignored; they cannot occur in a legal system.
//  - ERR responder, when sel_q==ERR:
//      slv_rsp_valid_o = cnt_q>0; rdata=ErrData; err=1.
//      Latency 1 cycle after acceptance; one response per cycle.
//      ERR requests never reach any mst port.
//  - Request-to-mst path is combinational (0 cycles) unless MEM_DEMUX_REQ_CUT_EN.
//  - Reset (also mid-transaction): cnt_q=0, sel_q=0.
//      All mst_req_valid_o=0, slv_rsp_valid_o=0, slv_req_ready_o follows accept (=1 after reset).
//      In-flight responses are dropped.
//  - Payload outputs are don't-care while their valid is 0.
// CONFIGURATION
//  MEM_DEMUX_REQ_CUT_EN defined:
//    - Spill register (mem_demux_cut) between upstream and decode; adds 1 cycle request latency.
//    - Full throughput; no combinational ready path upstream.
//  MEM_DEMUX_REQ_CUT_EN undefined: fully combinational request path, as described above.
// STRUCTURE
//  mem_demux_pkg: rule_t, idx width function, ERR_DATA default, cnt width localparam.
//  Instantiates addr_decode (existing, Napot=0).
//  One sub-module: mem_demux_cut (2-entry valid/ready spill register), only under the macro.
// TESTING
//  1 Map p0=[0x0,0x1000), p1=[0x1000,0x2000); read 0x1004, p1 rsp rdata=0x55
//    -> mst_req_valid_o=4'b0010, slv rsp rdata=0x55, err=0.
//  2 4 back-to-back reads to p0, p0 withholds rsp -> 4 accepted, 5th stalls (ready=0).
//    After 1 rsp, the 5th is accepted the next cycle.
//  3 Req p0 outstanding, then req p1 -> p1 stalled until p0 rsp handshake; responses in order.
//  4 Addr 0x8000, default disabled -> no mst valid; next cycle rsp err=1, rdata=0xBADCAB1E.
//  5 Same addr with en_default_idx_i=1, default=3 -> routed to p3, no error.
//  6 Assert rst_i with cnt_q=2 -> next cycle all valids 0, cnt_q=0; new req accepted immediately.

Source files
------------

// File: rtl/mem_demux_pkg.sv
// mem_demux_pkg: address-map rule type, error read data and index/counter sizing helpers
package mem_demux_pkg;
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } rule_t;
  localparam logic [31:0] ERR_DATA = 32'hBADCAB1E;
  localparam int unsigned MAX_TRANS_DEF = 4;
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int unsigned cnt_width(input int unsigned max_trans);
    return idx_width(max_trans + 1);
  endfunction
endpackage

// File: rtl/mem_req_demux_if.sv
// mem_req_demux_if: upstream request/response stream plus per-port downstream bus; slave = demux side
interface mem_req_demux_if #(
  parameter int unsigned NoMstPorts = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  logic slv_req_valid, slv_req_ready, slv_req_we;
  logic [AddrWidth-1:0] slv_req_addr;
  logic [DataWidth-1:0] slv_req_wdata;
  logic [StrbWidth-1:0] slv_req_strb;
  logic slv_rsp_valid, slv_rsp_ready, slv_rsp_err;
  logic [DataWidth-1:0] slv_rsp_rdata;
  logic [NoMstPorts-1:0] mst_req_valid, mst_req_ready;
  logic mst_req_we;
  logic [AddrWidth-1:0] mst_req_addr;
  logic [DataWidth-1:0] mst_req_wdata;
  logic [StrbWidth-1:0] mst_req_strb;
  logic [NoMstPorts-1:0] mst_rsp_valid, mst_rsp_ready, mst_rsp_err;
  logic [NoMstPorts-1:0][DataWidth-1:0] mst_rsp_rdata;
  modport slave (
    input slv_req_valid, slv_req_we, slv_req_addr, slv_req_wdata, slv_req_strb, slv_rsp_ready,
    input mst_req_ready, mst_rsp_valid, mst_rsp_err, mst_rsp_rdata,
    output slv_req_ready, slv_rsp_valid, slv_rsp_err, slv_rsp_rdata,
    output mst_req_valid, mst_req_we, mst_req_addr, mst_req_wdata, mst_req_strb, mst_rsp_ready
  );
  modport master (
    output slv_req_valid, slv_req_we, slv_req_addr, slv_req_wdata, slv_req_strb, slv_rsp_ready,
    output mst_req_ready, mst_rsp_valid, mst_rsp_err, mst_rsp_rdata,
    input slv_req_ready, slv_rsp_valid, slv_rsp_err, slv_rsp_rdata,
    input mst_req_valid, mst_req_we, mst_req_addr, mst_req_wdata, mst_req_strb, mst_rsp_ready
  );
endinterface

// File: rtl/addr_decode.sv
// addr_decode: maps an address to a port index via [start,end) rules (or NAPOT masks); last match wins
module addr_decode
  import mem_demux_pkg::*;
#(
  parameter int unsigned NoIndices = 4,
  parameter int unsigned NoRules = 4,
  parameter type addr_t = logic [31:0],
  parameter type rule_t = mem_demux_pkg::rule_t,
  parameter bit Napot = 1'b0
) (
  input addr_t addr_i,
  input rule_t addr_map_i [NoRules],
  output logic [mem_demux_pkg::idx_width(NoIndices)-1:0] idx_o,
  output logic dec_valid_o,
  output logic dec_error_o,
  input logic en_default_idx_i,
  input logic [mem_demux_pkg::idx_width(NoIndices)-1:0] default_idx_i
);
  localparam int unsigned IdxW = idx_width(NoIndices);
  logic matched;
  addr_t lo, hi;
  always_comb begin
    matched = 1'b0;
    idx_o = en_default_idx_i ? default_idx_i : '0;
    lo = '0;
    hi = '0;
    for (int unsigned i = 0; i < NoRules; i++) begin
      lo = addr_t'(addr_map_i[i].start_addr);
      hi = addr_t'(addr_map_i[i].end_addr);
      if ((addr_map_i[i].idx < NoIndices) &&
          (Napot ? ((addr_i & hi) == (lo & hi)) : (addr_i >= lo && addr_i < hi))) begin
        matched = 1'b1;
        idx_o = IdxW'(addr_map_i[i].idx);
      end
    end
    dec_valid_o = matched | en_default_idx_i;
    dec_error_o = ~dec_valid_o;
  end
endmodule

// File: rtl/mem_demux_cut.sv
// mem_demux_cut: 2-entry valid/ready spill register; full throughput, registered ready and valid
module mem_demux_cut #(
  parameter int unsigned Width = 8
) (
  input logic clk_i,
  input logic rst_i,
  input logic valid_i,
  output logic ready_o,
  input logic [Width-1:0] data_i,
  output logic valid_o,
  input logic ready_i,
  output logic [Width-1:0] data_o
);
  logic a_full_q, a_full_d, b_full_q, b_full_d, a_fill, b_fill;
  logic [Width-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
  // B always holds the older beat, so it is presented first
  always_comb begin
    ready_o = ~a_full_q | ~b_full_q;
    valid_o = a_full_q | b_full_q;
    data_o = b_full_q ? b_data_q : a_data_q;
    a_fill = valid_i & ready_o;
    b_fill = a_full_q & ~b_full_q & ~ready_i;
    a_full_d = a_fill | (a_full_q & b_full_q);
    b_full_d = b_fill | (b_full_q & ~ready_i);
    a_data_d = a_fill ? data_i : a_data_q;
    b_data_d = b_fill ? a_data_q : b_data_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      a_full_q <= a_full_d;
      b_full_q <= b_full_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
    end
  end
endmodule

// File: rtl/mem_req_demux.sv
// mem_req_demux: routes a memory request stream to NoMstPorts ports, locking on one target while busy.
// MEM_DEMUX_REQ_CUT_EN inserts a spill register ahead of the decoder.
module mem_req_demux #(
  parameter int unsigned NoMstPorts = 4,
  parameter int unsigned NoRules = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxTrans = mem_demux_pkg::MAX_TRANS_DEF,
  parameter type rule_t = mem_demux_pkg::rule_t,
  parameter logic [DataWidth-1:0] ErrData = DataWidth'(mem_demux_pkg::ERR_DATA)
) (
  input logic clk_i,
  input logic rst_i,
  input rule_t addr_map_i [NoRules],
  input logic en_default_idx_i,
  input logic [mem_demux_pkg::idx_width(NoMstPorts)-1:0] default_idx_i,
  mem_req_demux_if.slave bus
);
  import mem_demux_pkg::*;
  localparam int unsigned IdxW = idx_width(NoMstPorts);
  localparam int unsigned SelW = idx_width(NoMstPorts + 1);
  localparam int unsigned CntW = cnt_width(MaxTrans);
  localparam logic [SelW-1:0] Err = SelW'(NoMstPorts);
  typedef logic [AddrWidth-1:0] addr_t;
  logic req_valid, req_ready, req_we;
  addr_t req_addr;
  logic [DataWidth-1:0] req_wdata;
  logic [DataWidth/8-1:0] req_strb;
`ifdef MEM_DEMUX_REQ_CUT_EN
  localparam int unsigned ReqW = AddrWidth + 1 + DataWidth + DataWidth / 8;
  logic [ReqW-1:0] cut_data;
  mem_demux_cut #(.Width(ReqW)) i_cut (
    .clk_i, .rst_i,
    .valid_i(bus.slv_req_valid), .ready_o(bus.slv_req_ready),
    .data_i({bus.slv_req_addr, bus.slv_req_we, bus.slv_req_wdata, bus.slv_req_strb}),
    .valid_o(req_valid), .ready_i(req_ready), .data_o(cut_data)
  );
  assign {req_addr, req_we, req_wdata, req_strb} = cut_data;
`else
  assign req_valid = bus.slv_req_valid;
  assign req_addr = bus.slv_req_addr;
  assign req_we = bus.slv_req_we;
  assign req_wdata = bus.slv_req_wdata;
  assign req_strb = bus.slv_req_strb;
  assign bus.slv_req_ready = req_ready;
`endif
  logic [IdxW-1:0] dec_idx, sel_idx;
  logic dec_valid, dec_error;
  addr_decode #(
    .NoIndices(NoMstPorts), .NoRules(NoRules), .addr_t(addr_t), .rule_t(rule_t), .Napot(1'b0)
  ) i_dec (
    .addr_i(req_addr), .addr_map_i, .idx_o(dec_idx), .dec_valid_o(dec_valid),
    .dec_error_o(dec_error), .en_default_idx_i, .default_idx_i
  );
  assign bus.mst_req_addr = req_addr;
  assign bus.mst_req_we = req_we;
  assign bus.mst_req_wdata = req_wdata;
  assign bus.mst_req_strb = req_strb;
  logic [SelW-1:0] sel_q, sel_d, tgt;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic accept, req_hs, rsp_hs, sel_err;
  // responses with nothing outstanding (e.g. in flight across a reset) are dropped
  always_comb begin
    tgt = (dec_error | ~dec_valid) ? Err : SelW'(dec_idx);
    accept = (cnt_q == '0) | ((sel_q == tgt) & (cnt_q < CntW'(MaxTrans)));
    req_ready = accept & ((tgt == Err) | bus.mst_req_ready[dec_idx]);
    req_hs = req_valid & req_ready;
    sel_err = sel_q == Err;
    sel_idx = sel_q[IdxW-1:0];
    bus.mst_req_valid = '0;
    bus.mst_req_valid[dec_idx] = req_valid & accept & (tgt != Err);
    bus.mst_rsp_ready = '0;
    bus.mst_rsp_ready[sel_idx] = bus.slv_rsp_ready & ~sel_err;
    bus.slv_rsp_valid = (cnt_q != '0) & (sel_err | bus.mst_rsp_valid[sel_idx]);
    bus.slv_rsp_rdata = sel_err ? ErrData : bus.mst_rsp_rdata[sel_idx];
    bus.slv_rsp_err = sel_err | bus.mst_rsp_err[sel_idx];
    rsp_hs = bus.slv_rsp_valid & bus.slv_rsp_ready;
    cnt_d = cnt_q + CntW'(req_hs) - CntW'(rsp_hs);
    sel_d = req_hs ? tgt : sel_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end
endmodule

// File: tb/tb_mem_req_demux.sv
// tb_mem_req_demux: directed scenarios for routing, outstanding limit, target switch, decode error, reset
module tb_mem_req_demux;
  import mem_demux_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_def = 1'b0;
  logic [1:0] def_idx = 2'd0;
  rule_t addr_map [4];
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  mem_req_demux_if #(.NoMstPorts(4), .AddrWidth(32), .DataWidth(32)) bus ();
  mem_req_demux dut (
    .clk_i(clk), .rst_i(rst), .addr_map_i(addr_map),
    .en_default_idx_i(en_def), .default_idx_i(def_idx), .bus(bus)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive_idle;
    bus.slv_req_valid = 1'b0;
    bus.slv_req_addr = '0;
    bus.slv_req_we = 1'b0;
    bus.slv_req_wdata = '0;
    bus.slv_req_strb = '0;
    bus.slv_rsp_ready = 1'b1;
    bus.mst_req_ready = '1;
    bus.mst_rsp_valid = '0;
    bus.mst_rsp_rdata = '0;
    bus.mst_rsp_err = '0;
  endtask
  task automatic test_reset;
    for (int i = 0; i < 4; i++) addr_map[i] = '{idx: i, start_addr: 32'h1000 * i, end_addr: 32'h1000 * (i + 1)};
    drive_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++; if (bus.mst_req_valid !== 4'b0000) $display("FAIL reset_mst_valid got %b exp 0000", bus.mst_req_valid); else passed++;
    total++; if (bus.slv_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", bus.slv_rsp_valid); else passed++;
    total++; if (bus.slv_req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", bus.slv_req_ready); else passed++;
  endtask
  task automatic test_route;
    bus.mst_req_ready = 4'b1101;
    bus.slv_req_valid = 1'b1;
    bus.slv_req_addr = 32'h1004;
    #1;
    total++; if (bus.mst_req_valid !== 4'b0010) $display("FAIL route_valid got %b exp 0010", bus.mst_req_valid); else passed++;
    total++; if (bus.slv_req_ready !== 1'b0) $display("FAIL route_ready_low got %b exp 0", bus.slv_req_ready); else passed++;
    bus.mst_req_ready = '1;
    #1;
    total++; if (bus.slv_req_ready !== 1'b1) $display("FAIL route_ready got %b exp 1", bus.slv_req_ready); else passed++;
    total++; if (bus.mst_req_addr !== 32'h1004) $display("FAIL route_addr got %h exp 00001004", bus.mst_req_addr); else passed++;
    tick();
    bus.slv_req_valid = 1'b0;
    bus.mst_rsp_valid = 4'b0010;
    bus.mst_rsp_rdata[1] = 32'h55;
    #1;
    total++; if (bus.slv_rsp_valid !== 1'b1) $display("FAIL route_rsp_valid got %b exp 1", bus.slv_rsp_valid); else passed++;
    total++; if (bus.slv_rsp_rdata !== 32'h55) $display("FAIL route_rdata got %h exp 00000055", bus.slv_rsp_rdata); else passed++;
    total++; if (bus.slv_rsp_err !== 1'b0) $display("FAIL route_err got %b exp 0", bus.slv_rsp_err); else passed++;
    total++; if (bus.mst_rsp_ready !== 4'b0010) $display("FAIL route_rsp_ready got %b exp 0010", bus.mst_rsp_ready); else passed++;
    tick();
    bus.mst_rsp_valid = '0;
    #1;
    total++; if (bus.slv_rsp_valid !== 1'b0) $display("FAIL route_rsp_done got %b exp 0", bus.slv_rsp_valid); else passed++;
  endtask
  task automatic test_max_outstanding;
    bus.slv_req_valid = 1'b1;
    bus.slv_req_addr = 32'h10;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (bus.slv_req_ready !== 1'b1) $display("FAIL outst_accept%0d got %b exp 1", i, bus.slv_req_ready); else passed++;
      tick();
    end
    #1;
    total++; if (bus.slv_req_ready !== 1'b0) $display("FAIL outst_stall_ready got %b exp 0", bus.slv_req_ready); else passed++;
    total++; if (bus.mst_req_valid !== 4'b0000) $display("FAIL outst_stall_valid got %b exp 0000", bus.mst_req_valid); else passed++;
    bus.mst_rsp_valid = 4'b0001;
    #1;
    total++; if (bus.slv_rsp_valid !== 1'b1) $display("FAIL outst_rsp_valid got %b exp 1", bus.slv_rsp_valid); else passed++;
    total++; if (bus.slv_req_ready !== 1'b0) $display("FAIL outst_rsp_cycle_ready got %b exp 0", bus.slv_req_ready); else passed++;
    tick();
    bus.mst_rsp_valid = '0;
    #1;
    total++; if (bus.slv_req_ready !== 1'b1) $display("FAIL outst_resume_ready got %b exp 1", bus.slv_req_ready); else passed++;
    total++; if (bus.mst_req_valid !== 4'b0001) $display("FAIL outst_resume_valid got %b exp 0001", bus.mst_req_valid); else passed++;
    tick();
    bus.slv_req_valid = 1'b0;
    bus.mst_rsp_valid = 4'b0001;
    repeat (4) tick();
    bus.mst_rsp_valid = '0;
    #1;
    total++; if (dut.cnt_q !== 3'd0) $display("FAIL outst_drained got %0d exp 0", dut.cnt_q); else passed++;
  endtask
  task automatic test_switch;
    bus.slv_req_valid = 1'b1;
    bus.slv_req_addr = 32'h20;
    #1;
    total++; if (bus.mst_req_valid !== 4'b0001) $display("FAIL switch_first_valid got %b exp 0001", bus.mst_req_valid); else passed++;
    tick();
    bus.slv_req_addr = 32'h1008;
    #1;
    total++; if (bus.slv_req_ready !== 1'b0) $display("FAIL switch_stall_ready got %b exp 0", bus.slv_req_ready); else passed++;
    total++; if (bus.mst_req_valid !== 4'b0000) $display("FAIL switch_stall_valid got %b exp 0000", bus.mst_req_valid); else passed++;
    tick();
    bus.mst_rsp_valid = 4'b0001;
    bus.mst_rsp_rdata[0] = 32'hA0;
    #1;
    total++; if (bus.slv_rsp_valid !== 1'b1) $display("FAIL switch_rsp0_valid got %b exp 1", bus.slv_rsp_valid); else passed++;
    total++; if (bus.slv_rsp_rdata !== 32'hA0) $display("FAIL switch_rsp0_rdata got %h exp 000000a0", bus.slv_rsp_rdata); else passed++;
    total++; if (bus.slv_req_ready !== 1'b0) $display("FAIL switch_rsp0_ready got %b exp 0", bus.slv_req_ready); else passed++;
    tick();
    bus.mst_rsp_valid = '0;
    #1;
    total++; if (bus.slv_req_ready !== 1'b1) $display("FAIL switch_go_ready got %b exp 1", bus.slv_req_ready); else passed++;
    total++; if (bus.mst_req_valid !== 4'b0010) $display("FAIL switch_go_valid got %b exp 0010", bus.mst_req_valid); else passed++;
    tick();
    bus.slv_req_valid = 1'b0;
    bus.mst_rsp_valid = 4'b0010;
    bus.mst_rsp_rdata[1] = 32'hB1;
    #1;
    total++; if (bus.slv_rsp_rdata !== 32'hB1) $display("FAIL switch_rsp1_rdata got %h exp 000000b1", bus.slv_rsp_rdata); else passed++;
    total++; if (bus.mst_rsp_ready !== 4'b0010) $display("FAIL switch_rsp1_ready got %b exp 0010", bus.mst_rsp_ready); else passed++;
    tick();
    bus.mst_rsp_valid = '0;
  endtask
  task automatic test_decode_error;
    bus.slv_req_valid = 1'b1;
    bus.slv_req_addr = 32'h8000;
    #1;
    total++; if (bus.mst_req_valid !== 4'b0000) $display("FAIL err_no_mst got %b exp 0000", bus.mst_req_valid); else passed++;
    total++; if (bus.slv_req_ready !== 1'b1) $display("FAIL err_ready got %b exp 1", bus.slv_req_ready); else passed++;
    tick();
    bus.slv_req_valid = 1'b0;
    #1;
    total++; if (bus.slv_rsp_valid !== 1'b1) $display("FAIL err_rsp_valid got %b exp 1", bus.slv_rsp_valid); else passed++;
    total++; if (bus.slv_rsp_err !== 1'b1) $display("FAIL err_flag got %b exp 1", bus.slv_rsp_err); else passed++;
    total++; if (bus.slv_rsp_rdata !== 32'hBADCAB1E) $display("FAIL err_rdata got %h exp badcab1e", bus.slv_rsp_rdata); else passed++;
    total++; if (bus.mst_rsp_ready !== 4'b0000) $display("FAIL err_mst_rsp_ready got %b exp 0000", bus.mst_rsp_ready); else passed++;
    tick();
    #1;
    total++; if (bus.slv_rsp_valid !== 1'b0) $display("FAIL err_single_rsp got %b exp 0", bus.slv_rsp_valid); else passed++;
  endtask
  task automatic test_default;
    en_def = 1'b1;
    def_idx = 2'd3;
    bus.slv_req_valid = 1'b1;
    bus.slv_req_addr = 32'h8000;
    #1;
    total++; if (bus.mst_req_valid !== 4'b1000) $display("FAIL def_valid got %b exp 1000", bus.mst_req_valid); else passed++;
    total++; if (bus.slv_req_ready !== 1'b1) $display("FAIL def_ready got %b exp 1", bus.slv_req_ready); else passed++;
    tick();
    bus.slv_req_valid = 1'b0;
    bus.mst_rsp_valid = 4'b1000;
    bus.mst_rsp_rdata[3] = 32'h33;
    #1;
    total++; if (bus.slv_rsp_valid !== 1'b1) $display("FAIL def_rsp_valid got %b exp 1", bus.slv_rsp_valid); else passed++;
    total++; if (bus.slv_rsp_rdata !== 32'h33) $display("FAIL def_rdata got %h exp 00000033", bus.slv_rsp_rdata); else passed++;
    total++; if (bus.slv_rsp_err !== 1'b0) $display("FAIL def_err got %b exp 0", bus.slv_rsp_err); else passed++;
    tick();
    bus.mst_rsp_valid = '0;
    en_def = 1'b0;
  endtask
  task automatic test_reset_mid;
    bus.slv_req_valid = 1'b1;
    bus.slv_req_addr = 32'h30;
    tick();
    tick();
    bus.slv_req_valid = 1'b0;
    #1;
    total++; if (dut.cnt_q !== 3'd2) $display("FAIL mid_cnt_before got %0d exp 2", dut.cnt_q); else passed++;
    rst = 1'b1;
    bus.mst_rsp_valid = 4'b0001;
    tick();
    rst = 1'b0;
    #1;
    total++; if (dut.cnt_q !== 3'd0) $display("FAIL mid_cnt_after got %0d exp 0", dut.cnt_q); else passed++;
    total++; if (bus.slv_rsp_valid !== 1'b0) $display("FAIL mid_rsp_dropped got %b exp 0", bus.slv_rsp_valid); else passed++;
    total++; if (bus.mst_req_valid !== 4'b0000) $display("FAIL mid_mst_valid got %b exp 0000", bus.mst_req_valid); else passed++;
    bus.mst_rsp_valid = '0;
    bus.slv_req_valid = 1'b1;
    bus.slv_req_addr = 32'h1000;
    #1;
    total++; if (bus.slv_req_ready !== 1'b1) $display("FAIL mid_new_ready got %b exp 1", bus.slv_req_ready); else passed++;
    total++; if (bus.mst_req_valid !== 4'b0010) $display("FAIL mid_new_valid got %b exp 0010", bus.mst_req_valid); else passed++;
    tick();
    bus.slv_req_valid = 1'b0;
    bus.mst_rsp_valid = 4'b0010;
    tick();
    bus.mst_rsp_valid = '0;
  endtask
  initial begin
    test_reset();
    test_route();
    test_max_outstanding();
    test_switch();
    test_decode_error();
    test_default();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
